// File: rtl/program_loader.sv
// Assembles 17-bit instruction words from a 3-byte serial stream and writes them to instruction memory.
// Latency: write strobe one cycle after the third byte; byte_ready drops during WRITE (>=4 cycles/word).
module program_loader #(
  parameter int IMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [5:0]  imem_addr,
  output logic [16:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [7:0] DEPTH_W = 8'(IMEM_DEPTH);

  state_t      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic [16:0] wdata_q, wdata_d;
  logic [6:0]  count_q, count_d;
  logic [6:0]  written_q, written_d;
  logic        error_q, error_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    written_d = written_q;
    error_d   = error_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_d   = word_count;
          written_d = 7'd0;
          addr_d    = 6'd0;
          error_d   = 1'b0;
          if (word_count == 7'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, word_count} > DEPTH_W) begin
            // Oversized requests fault up front so the address can never wrap.
            error_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_B0;
          end
        end
      end
      S_B0: begin
        if (byte_valid) begin
          wdata_d[16] = byte_in[0];
          if (byte_in[7:1] != 7'd0) error_d = 1'b1;
          state_d = S_B1;
        end
      end
      S_B1: begin
        if (byte_valid) begin
          wdata_d[15:8] = byte_in;
          state_d       = S_B2;
        end
      end
      S_B2: begin
        if (byte_valid) begin
          wdata_d[7:0] = byte_in;
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        written_d = written_q + 7'd1;
        if (written_d == count_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 6'd1;
          state_d = S_B0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 6'd0;
      wdata_q   <= 17'd0;
      count_q   <= 7'd0;
      written_q <= 7'd0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      count_q   <= count_d;
      written_q <= written_d;
      error_q   <= error_d;
    end
  end

  assign byte_ready = (state_q == S_B0) || (state_q == S_B1) || (state_q == S_B2);
  assign busy       = byte_ready || (state_q == S_WRITE);
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  // The CPU is released only after a clean, completed load.
  assign cpu_hold   = !((state_q == S_DONE) && !error_q);

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader with a byte-stream reference model.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [16:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  bytes_q[$];
  logic [5:0]  wr_addr[$];
  logic [16:0] wr_data[$];
  int          wr_cyc[$];
  logic [5:0]  exp_addr[$];
  logic [16:0] exp_data[$];
  logic        exp_err;

  program_loader #(.IMEM_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor; also checks the handshake is closed while writing.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
      tests = tests + 1;
      if (byte_ready !== 1'b0 || busy !== 1'b1) begin
        fails = fails + 1;
        $display("FAIL write_handshake: byte_ready=%b busy=%b required 0/1", byte_ready, busy);
      end
    end
  end

  // Reference: each word is {b0[0], b1, b2}; any nonzero b0[7:1] faults the load.
  task automatic build_model(input int wc);
    exp_addr.delete();
    exp_data.delete();
    exp_err = (wc > 64);
    if (wc >= 1 && wc <= 64) begin
      for (int i = 0; i < wc; i++) begin
        exp_addr.push_back(6'(i));
        exp_data.push_back({bytes_q[3*i][0], bytes_q[3*i+1], bytes_q[3*i+2]});
        if (bytes_q[3*i][7:1] != 7'd0) exp_err = 1'b1;
      end
    end
  endtask

  task automatic fill_random(input int nwords);
    bytes_q.delete();
    for (int i = 0; i < 3*nwords; i++) begin
      if (i % 3 == 0) bytes_q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1)));
      else bytes_q.push_back(8'($urandom));
    end
  endtask

  // Starts a load and feeds bytes_q; vmode 0=always valid, 1=toggle, 2=random.
  // Returns at DONE, after max_bytes accepted, or on timeout.
  task automatic run_load(input int wc, input int vmode, input bit pulse_start,
                          input int max_bytes, output bit timed_out);
    int idx;
    bit tog;
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    timed_out = 1'b1;
    @(negedge clk);
    start = 1'b1;
    word_count = 7'(wc);
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    tog = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (done || idx >= max_bytes) begin
        timed_out = 1'b0;
        break;
      end
      if (idx < bytes_q.size()) begin
        byte_in = bytes_q[idx];
        case (vmode)
          0: byte_valid = 1'b1;
          1: byte_valid = tog;
          default: byte_valid = ($urandom_range(0, 99) < 60);
        endcase
      end else begin
        byte_valid = 1'b0;
      end
      tog = ~tog;
      if (pulse_start) begin
        start = ($urandom_range(0, 3) == 0);
        word_count = 7'($urandom);
      end
      @(posedge clk);
      if (byte_valid && byte_ready) idx++;
      @(negedge clk);
      start = 1'b0;
    end
    byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (imem_we !== 1'b0)      begin fails++; $display("FAIL rst_we: got %b required 0", imem_we); end
    tests++; if (imem_addr !== 6'd0)    begin fails++; $display("FAIL rst_addr: got %0d required 0", imem_addr); end
    tests++; if (imem_wdata !== 17'd0)  begin fails++; $display("FAIL rst_wdata: got %h required 0", imem_wdata); end
    tests++; if (byte_ready !== 1'b0)   begin fails++; $display("FAIL rst_ready: got %b required 0", byte_ready); end
    tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL rst_busy: got %b required 0", busy); end
    tests++; if (done !== 1'b0)         begin fails++; $display("FAIL rst_done: got %b required 0", done); end
    tests++; if (error !== 1'b0)        begin fails++; $display("FAIL rst_error: got %b required 0", error); end
    tests++; if (cpu_hold !== 1'b1)     begin fails++; $display("FAIL rst_hold: got %b required 1", cpu_hold); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit to;
    bytes_q = '{8'h01, 8'hA5, 8'h3C, 8'h00, 8'h12, 8'h34};
    build_model(2);
    run_load(2, 0, 1'b0, 999, to);
    tests++; if (to) begin fails++; $display("FAIL basic_timeout: no DONE"); end
    tests++; if (wr_addr.size() != 2) begin fails++; $display("FAIL basic_nwrites: got %0d required 2", wr_addr.size()); end
    for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
      tests++;
      if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
        fails++; $display("FAIL basic_word%0d: got %h@%0d required %h@%0d", i, wr_data[i], wr_addr[i], exp_data[i], exp_addr[i]);
      end
    end
    if (wr_cyc.size() == 2) begin
      tests++; if (wr_cyc[1] - wr_cyc[0] != 4) begin fails++; $display("FAIL basic_spacing: got %0d cycles required 4", wr_cyc[1] - wr_cyc[0]); end
    end
    tests++; if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      fails++; $display("FAIL basic_status: done/err/hold=%b%b%b required 100", done, error, cpu_hold);
    end
  endtask

  task automatic test_toggle;
    bit to;
    bytes_q = '{8'h00, 8'hDE, 8'hAD};
    build_model(1);
    run_load(1, 1, 1'b0, 999, to);
    tests++; if (to || wr_addr.size() != 1) begin fails++; $display("FAIL toggle_nwrites: got %0d required 1", wr_addr.size()); end
    else begin
      tests++; if (wr_addr[0] !== 6'd0 || wr_data[0] !== exp_data[0]) begin
        fails++; $display("FAIL toggle_word: got %h@%0d required %h@0", wr_data[0], wr_addr[0], exp_data[0]);
      end
    end
  endtask

  task automatic test_zero_overflow;
    bit to;
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    bytes_q.delete();
    run_load(0, 0, 1'b0, 999, to);
    tests++; if (done !== 1'b1 || busy !== 1'b0 || wr_addr.size() != 0) begin
      fails++; $display("FAIL zero_count: done=%b busy=%b writes=%0d required 1/0/0", done, busy, wr_addr.size());
    end
    run_load(65, 0, 1'b0, 999, to);
    tests++; if (to || done !== 1'b1 || error !== 1'b1 || cpu_hold !== 1'b1 || wr_addr.size() != 0) begin
      fails++; $display("FAIL overflow: done=%b err=%b hold=%b writes=%0d required 1/1/1/0", done, error, cpu_hold, wr_addr.size());
    end
  endtask

  task automatic test_bad_byte0;
    bit to;
    bytes_q = '{8'h81, 8'h5A, 8'hC3};
    build_model(1);
    run_load(1, 0, 1'b0, 999, to);
    tests++; if (to || wr_data.size() != 1 || wr_data[0] !== 17'h15AC3) begin
      fails++; $display("FAIL bad_byte0_word: writes=%0d required 1 of 15ac3", wr_data.size());
    end
    tests++; if (error !== exp_err || cpu_hold !== 1'b1 || done !== 1'b1) begin
      fails++; $display("FAIL bad_byte0_status: err=%b hold=%b done=%b required 1/1/1", error, cpu_hold, done);
    end
  endtask

  task automatic test_random_loads;
    bit to;
    int wcs[4] = '{64, 1, 7, 64};
    for (int t = 0; t < 4; t++) begin
      fill_random(wcs[t]);
      build_model(wcs[t]);
      run_load(wcs[t], 2, 1'b1, 999, to);
      tests++; if (to || wr_addr.size() != exp_addr.size()) begin
        fails++; $display("FAIL rand%0d_nwrites: got %0d required %0d", t, wr_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < wr_addr.size(); i++) begin
          tests++;
          if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            fails++; $display("FAIL rand%0d_word%0d: got %h@%0d required %h@%0d", t, i, wr_data[i], wr_addr[i], exp_data[i], exp_addr[i]);
          end
        end
      end
      tests++; if (done !== 1'b1 || error !== exp_err || cpu_hold !== exp_err) begin
        fails++; $display("FAIL rand%0d_status: done=%b err=%b hold=%b required 1/%b/%b", t, done, error, cpu_hold, exp_err, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    int nw;
    fill_random(4);
    run_load(4, 0, 1'b0, 8, to);
    rst = 1'b0;
    nw = wr_addr.size();
    @(negedge clk);
    tests++; if (nw != 2) begin fails++; $display("FAIL mid_prewrites: got %0d required 2", nw); end
    tests++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || byte_ready !== 1'b0 || imem_we !== 1'b0 ||
                 cpu_hold !== 1'b1 || imem_addr !== 6'd0 || imem_wdata !== 17'd0) begin
      fails++; $display("FAIL mid_reset_outputs: busy=%b done=%b err=%b rdy=%b we=%b hold=%b addr=%0d wdata=%h required reset values",
                        busy, done, error, byte_ready, imem_we, cpu_hold, imem_addr, imem_wdata);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (wr_addr.size() != nw) begin fails++; $display("FAIL mid_no_more_writes: got %0d required %0d", wr_addr.size(), nw); end
    fill_random(1);
    build_model(1);
    run_load(1, 2, 1'b0, 999, to);
    tests++; if (to || wr_addr.size() != 1 || wr_addr[0] !== 6'd0 || wr_data[0] !== exp_data[0]) begin
      fails++; $display("FAIL mid_restart: writes=%0d required one word %h@0", wr_addr.size(), exp_data[0]);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; word_count = 7'd0; byte_in = 8'd0; byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_toggle();
    test_zero_overflow();
    test_bad_byte0();
    test_random_loads();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: IMEM_DEPTH, default 64, number of instruction-memory words; address width fixed at 6 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (sampled on rising clk; 0 = reset).
REQ-004 start  input  1  load request; sampled only in IDLE or DONE.
REQ-005 word_count  input  7  number of 17-bit words to load; latched on accepted start.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  6  instruction-memory write address.
REQ-011 imem_wdata  output  17  assembled instruction word.
REQ-012 cpu_hold  output  1  1 = CPU held in reset / stalled; 0 = CPU may run.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  last load completed; held until next accepted start.
REQ-015 error  output  1  sticky fault flag for the current load.

Function
REQ-016 States: IDLE, B0, B1, B2, WRITE, DONE.
REQ-017 Byte transfer occurs only on a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 exactly in B0, B1, B2.
REQ-018 IDLE/DONE + start=1: latch word_count, clear error, set imem_addr=0, go to B0 next cycle; if word_count=0 go to DONE directly with no write; if word_count>IMEM_DEPTH, set error=1, go to DONE with no write.
REQ-019 B0 accepted byte: instr[16]=byte_in[0]; byte_in[7:1]!=0 sets error=1 (load continues); -> B1.
REQ-020 B1 accepted byte: instr[15:8]=byte_in; -> B2. B2 accepted byte: instr[7:0]=byte_in; -> WRITE.
REQ-021 No accepted byte: state holds indefinitely; partial word retained.
REQ-022 WRITE: imem_we=1 for exactly one cycle with imem_wdata = assembled word, imem_addr = current address; byte_ready=0.
REQ-023 After WRITE: if words written == latched count -> DONE; else imem_addr increments by 1 -> B0.
REQ-024 Latency: imem_we asserts the cycle after the third byte is accepted; minimum 4 cycles per word.
REQ-025 imem_addr never wraps; at most IMEM_DEPTH writes per load (guaranteed by REQ-018).
REQ-026 busy=1 in B0, B1, B2, WRITE; 0 otherwise.
REQ-027 cpu_hold=1 in IDLE, B0, B1, B2, WRITE; cpu_hold=0 in DONE only when error=0; with error=1 in DONE, cpu_hold stays 1.
REQ-028 done=1 only in DONE; leaves DONE only on start=1.
REQ-029 start while busy=1 is ignored; changes to word_count while busy=1 have no effect.
REQ-030 imem_we=0 in every state other than WRITE; imem_wdata value is don't-care when imem_we=0.

Reset
REQ-031 rst=0 at a rising edge: state=IDLE, imem_addr=0, imem_wdata=0, imem_we=0, byte_ready=0, busy=0, done=0, error=0, cpu_hold=1, word counter=0.
REQ-032 Reset mid-load aborts immediately; no further imem_we; already-written words are not rolled back; a new start reloads from address 0.
REQ-033 Reset has priority over start and byte handshake in the same cycle.

Verification
REQ-034 Release reset, start, word_count=2, bytes 01,A5,3C,00,12,34 with byte_valid held high -> writes 0x1A53C@0 then 0x01234@1, done=1, cpu_hold=0, error=0.
REQ-035 word_count=1, byte_valid toggled 1/0 each cycle -> only accepted bytes assembled; single write at addr 0; byte_ready low during WRITE.
REQ-036 word_count=0 -> DONE the cycle after start, no imem_we; word_count=65 -> DONE, error=1, cpu_hold=1, no imem_we.
REQ-037 byte0=0x81 in a 1-word load -> word 0x1xxxx written, error=1 in DONE, cpu_hold=1.
REQ-038 word_count=64 full load -> 64 writes, addresses 0..63, no wrap, done=1; start pulses during load ignored.
REQ-039 rst=0 after second byte of word 3 -> all outputs at reset values next cycle; restart with word_count=1 writes addr 0.
